// File: rtl/matrix_host_loader.sv
// matrix_host_loader: host-side sequencer for the matrix multiplier engine.
// Takes one job descriptor plus a byte stream, programs dims and values into
// the engine, requests a run, waits for ready under a watchdog, then opens
// the result read window. Every output comes straight from a flop.
module matrix_host_loader #(
  parameter int TIMEOUT   = 4096,
  parameter int RD_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  // job descriptor
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_m1x,
  input  logic [2:0] cfg_m1y,
  input  logic [2:0] cfg_m2x,
  input  logic [2:0] cfg_m2y,
  // element byte stream
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  // engine programming interface
  output logic [2:0] M1Xin,
  output logic [2:0] M1Yin,
  output logic [2:0] M2Xin,
  output logic [2:0] M2Yin,
  output logic       program_dim,
  output logic       program_val,
  output logic [7:0] data_in,
  output logic       start,
  input  logic       ready,
  output logic       result_read_ready,
  // status
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int RD_W = $clog2(RD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(RD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DIM, LOAD, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [2:0] m1x;
    logic [2:0] m1y;
    logic [2:0] m2x;
    logic [2:0] m2y;
  } dims_t;

  state_t          state, state_d;
  dims_t           dims, dims_d, cfg_dims;
  logic            cfg_ok;
  logic [6:0]      cfg_total;
  logic [6:0]      total, total_d;
  logic [6:0]      elem_cnt, elem_cnt_d, elem_nxt;
  logic            dim_cnt, dim_cnt_d;
  logic [WD_W-1:0] wd, wd_d;
  logic [RD_W-1:0] rd_cnt, rd_cnt_d;
  logic [7:0]      data_in_d;
  logic            program_dim_d, program_val_d, start_d, rrr_d, done_d, err_d;

  assign cfg_dims  = {cfg_m1x, cfg_m1y, cfg_m2x, cfg_m2y};
  // Inner dimensions must agree and no dimension may be empty.
  assign cfg_ok    = (cfg_m1x != 3'd0) && (cfg_m1y != 3'd0) &&
                     (cfg_m2x != 3'd0) && (cfg_m2y != 3'd0) &&
                     (cfg_m1y == cfg_m2x);
  // Byte count of both operands; 7*7 + 7*7 = 98 fits in 7 bits.
  assign cfg_total = 7'(cfg_m1x) * 7'(cfg_m1y) + 7'(cfg_m2x) * 7'(cfg_m2y);
  assign elem_nxt  = elem_cnt + 7'd1;

  // Dims are driven from the latched descriptor and survive the return to
  // IDLE; only a new accepted descriptor or reset changes them.
  assign {M1Xin, M1Yin, M2Xin, M2Yin} = dims;

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d       = state;
    dims_d        = dims;
    total_d       = total;
    elem_cnt_d    = elem_cnt;
    dim_cnt_d     = dim_cnt;
    wd_d          = wd;
    rd_cnt_d      = rd_cnt;
    data_in_d     = data_in;
    program_dim_d = 1'b0;
    program_val_d = 1'b0;
    start_d       = 1'b0;
    rrr_d         = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_ok) begin
            dims_d        = cfg_dims;
            total_d       = cfg_total;
            elem_cnt_d    = 7'd0;
            dim_cnt_d     = 1'b0;
            program_dim_d = 1'b1;
            state_d       = DIM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // program_dim was raised on entry; hold it one more cycle.
      DIM: begin
        if (!dim_cnt) begin
          program_dim_d = 1'b1;
          dim_cnt_d     = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      // s_ready is high for the whole state, so s_valid alone is a transfer.
      LOAD: begin
        if (s_valid) begin
          data_in_d     = s_data;
          program_val_d = 1'b1;
          elem_cnt_d    = elem_nxt;
          if (elem_nxt == total) begin
            wd_d    = '0;
            state_d = RUN;
          end
        end
      end
      // First RUN cycle raises start; ready only counts once start is up,
      // and it beats a watchdog expiry on the same edge.
      RUN: begin
        if (start && ready) begin
          rd_cnt_d = '0;
          rrr_d    = 1'b1;
          state_d  = DRAIN;
        end else if (wd == WD_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d    = wd + 1'b1;
          start_d = 1'b1;
        end
      end
      // Read window was opened on entry; close it after RD_CYCLES cycles.
      DRAIN: begin
        if (rd_cnt == RD_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rd_cnt_d = rd_cnt + 1'b1;
          rrr_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and all outputs registered; handshake flags follow
  // the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      dims              <= '0;
      total             <= '0;
      elem_cnt          <= '0;
      dim_cnt           <= 1'b0;
      wd                <= '0;
      rd_cnt            <= '0;
      data_in           <= '0;
      program_dim       <= 1'b0;
      program_val       <= 1'b0;
      start             <= 1'b0;
      result_read_ready <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      cfg_ready         <= 1'b1;
      s_ready           <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_d;
      dims              <= dims_d;
      total             <= total_d;
      elem_cnt          <= elem_cnt_d;
      dim_cnt           <= dim_cnt_d;
      wd                <= wd_d;
      rd_cnt            <= rd_cnt_d;
      data_in           <= data_in_d;
      program_dim       <= program_dim_d;
      program_val       <= program_val_d;
      start             <= start_d;
      result_read_ready <= rrr_d;
      done              <= done_d;
      err               <= err_d;
      cfg_ready         <= (state_d == IDLE);
      s_ready           <= (state_d == LOAD);
      busy              <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_matrix_host_loader.sv
// tb_matrix_host_loader: randomized jobs against a descriptor-level model of
// the loader (byte counts, data order and cycle distances from spec rules).
module tb_matrix_host_loader;

  localparam int TO = 100;
  localparam int RD = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_m1x = '0, cfg_m1y = '0, cfg_m2x = '0, cfg_m2y = '0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       ready = 1'b0;
  logic       cfg_ready, s_ready, program_dim, program_val, start;
  logic       result_read_ready, busy, done, err;
  logic [2:0] M1Xin, M1Yin, M2Xin, M2Yin;
  logic [7:0] data_in;
  logic [28:0] outs;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  matrix_host_loader #(.TIMEOUT(TO), .RD_CYCLES(RD)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m1x(cfg_m1x), .cfg_m1y(cfg_m1y), .cfg_m2x(cfg_m2x), .cfg_m2y(cfg_m2y),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .M1Xin(M1Xin), .M1Yin(M1Yin), .M2Xin(M2Xin), .M2Yin(M2Yin),
    .program_dim(program_dim), .program_val(program_val), .data_in(data_in),
    .start(start), .ready(ready), .result_read_ready(result_read_ready),
    .busy(busy), .done(done), .err(err)
  );

  assign outs = {cfg_ready, s_ready, M1Xin, M1Yin, M2Xin, M2Yin, program_dim,
                 program_val, data_in, start, result_read_ready, busy, done, err};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: per-job event counts and first/last cycle stamps.
  int pd_cnt, pd_first, pv_cnt, pv_first, pv_last, st_cnt, st_first;
  int rr_cnt, rr_first, done_cnt, done_cyc, err_cnt, err_cyc, busy_cnt;
  logic [11:0] pd_dims;
  logic [7:0]  pv_q[$];
  bit          mon_clr = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      pd_cnt <= 0; pv_cnt <= 0; st_cnt <= 0; rr_cnt <= 0;
      done_cnt <= 0; err_cnt <= 0; busy_cnt <= 0;
      pd_first <= 0; pv_first <= 0; pv_last <= 0; st_first <= 0;
      rr_first <= 0; done_cyc <= 0; err_cyc <= 0; pd_dims <= '0;
      pv_q.delete();
    end else begin
      if (program_dim) begin
        if (pd_cnt == 0) begin pd_first <= cyc; pd_dims <= {M1Xin, M1Yin, M2Xin, M2Yin}; end
        pd_cnt <= pd_cnt + 1;
      end
      if (program_val) begin
        if (pv_cnt == 0) pv_first <= cyc;
        pv_last <= cyc;
        pv_cnt  <= pv_cnt + 1;
        pv_q.push_back(data_in);
      end
      if (start) begin
        if (st_cnt == 0) st_first <= cyc;
        st_cnt <= st_cnt + 1;
      end
      if (result_read_ready) begin
        if (rr_cnt == 0) rr_first <= cyc;
        rr_cnt <= rr_cnt + 1;
      end
      if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (err)  begin err_cnt  <= err_cnt + 1;  err_cyc  <= cyc; end
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_reset();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  // Present a descriptor for one edge; n is the edge that sampled it.
  task automatic send_cfg(input logic [2:0] a, b, c, d, output int n);
    cfg_m1x = a; cfg_m1y = b; cfg_m2x = c; cfg_m2y = d;
    cfg_valid = 1'b1;
    tick();
    n = cyc;
    cfg_valid = 1'b0;
  endtask

  // pat: 0 all ones, 1 ascending from 1, 2 random. stall: 0 none, 1 toggle,
  // 2 random (plus stray descriptors). rdly: edges after start rose at which
  // ready is sampled high; <=0 means never.
  task automatic run_job(input string tag, input logic [2:0] a, b, c, d,
                         input int pat, input int stall, input int rdly);
    int n, tot, idx, guard, s, r, nmis;
    bit ok, acc, tog;
    logic [7:0] bytes[$];
    ok  = (a != 0) && (b != 0) && (c != 0) && (d != 0) && (b == c);
    tot = int'(a) * int'(b) + int'(c) * int'(d);
    mon_reset();
    send_cfg(a, b, c, d, n);
    if (!ok) begin
      repeat (4) tick();
      chk({tag, ".err_cnt"}, 32'(err_cnt), 1);
      chk({tag, ".err_at"},  32'(err_cyc), 32'(n));
      chk({tag, ".pd"},      32'(pd_cnt), 0);
      chk({tag, ".pv"},      32'(pv_cnt), 0);
      chk({tag, ".busy"},    32'(busy_cnt), 0);
      chk({tag, ".cfg_rdy"}, 32'(cfg_ready), 1);
      return;
    end
    for (int i = 0; i < tot; i++)
      bytes.push_back(pat == 0 ? 8'd1 : pat == 1 ? 8'(i + 1) : 8'($urandom_range(0, 255)));
    idx = 0; guard = 0; tog = 1'b1;
    while (idx < tot && guard < 1000) begin
      s_valid = (stall == 0) ? 1'b1 : (stall == 1) ? tog : 1'($urandom_range(0, 1));
      tog     = ~tog;
      s_data  = bytes[idx];
      if (stall == 2) begin
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_m1x = 3'($urandom); cfg_m1y = 3'($urandom);
        cfg_m2x = 3'($urandom); cfg_m2y = 3'($urandom);
      end
      acc = s_valid && s_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    cfg_valid = 1'b0;
    chk({tag, ".load_done"}, 32'(idx), 32'(tot));
    // Extra byte right after the last one must not be taken.
    s_valid = 1'b1; s_data = 8'hA5;
    chk({tag, ".no_extra"}, 32'(s_ready), 0);
    tick(); tick();
    s_valid = 1'b0;
    guard = 0;
    while (st_cnt == 0 && guard < 20) begin tick(); guard++; end
    chk({tag, ".start_seen"}, 32'(st_cnt != 0), 1);
    s = st_first;
    r = -1;
    if (rdly > 0) begin
      guard = 0;
      while (cyc < s + rdly - 1 && guard < 1000) begin tick(); guard++; end
      ready = 1'b1;
      tick();
      r = cyc;
      ready = 1'b0;
    end
    guard = 0;
    while (done_cnt == 0 && err_cnt == 0 && guard < TO + RD + 50) begin tick(); guard++; end
    tick();
    chk({tag, ".pd_cnt"},   32'(pd_cnt), 2);
    chk({tag, ".pd_first"}, 32'(pd_first), 32'(n));
    chk({tag, ".pd_dims"},  32'(pd_dims), 32'({a, b, c, d}));
    chk({tag, ".pv_cnt"},   32'(pv_cnt), 32'(tot));
    chk({tag, ".pv_early"}, 32'(pv_first >= n + 2), 1);
    nmis = 0;
    for (int i = 0; i < tot && i < pv_q.size(); i++)
      if (pv_q[i] !== bytes[i]) nmis++;
    chk({tag, ".data"}, 32'(nmis), 0);
    if (stall == 0) chk({tag, ".pv_contig"}, 32'(pv_last - pv_first + 1), 32'(tot));
    chk({tag, ".start_at"}, 32'(st_first), 32'(pv_last + 1));
    if (rdly > 0) begin
      chk({tag, ".done_cnt"}, 32'(done_cnt), 1);
      chk({tag, ".err_cnt"},  32'(err_cnt), 0);
      chk({tag, ".rr_first"}, 32'(rr_first), 32'(r));
      chk({tag, ".rr_cnt"},   32'(rr_cnt), 32'(RD));
      chk({tag, ".done_at"},  32'(done_cyc), 32'(r + RD));
      chk({tag, ".st_len"},   32'(st_cnt), 32'(r - s));
    end else begin
      chk({tag, ".err_cnt"},  32'(err_cnt), 1);
      chk({tag, ".err_at"},   32'(err_cyc), 32'(s + TO));
      chk({tag, ".st_len"},   32'(st_cnt), 32'(TO));
      chk({tag, ".done_cnt"}, 32'(done_cnt), 0);
      chk({tag, ".rr_cnt"},   32'(rr_cnt), 0);
    end
    chk({tag, ".idle"},      32'({cfg_ready, busy, start}), 32'(3'b100));
    chk({tag, ".dims_held"}, 32'({M1Xin, M1Yin, M2Xin, M2Yin}), 32'({a, b, c, d}));
  endtask

  initial begin
    int n, idx, guard;
    logic [2:0] a, b, c, d;
    repeat (3) tick();
    chk("reset_state", 32'(outs), 32'(29'h1000_0000));
    rst = 1'b0;
    tick();

    run_job("valid",    3'd3, 3'd5, 3'd5, 3'd5, 0, 0, 20);
    run_job("bp",       3'd2, 3'd2, 3'd2, 3'd2, 1, 1, 5);
    run_job("rej_mis",  3'd3, 3'd4, 3'd5, 3'd5, 2, 0, 5);
    run_job("rej_zero", 3'd0, 3'd1, 3'd1, 3'd1, 2, 0, 5);
    run_job("timeout",  3'd1, 3'd1, 3'd1, 3'd1, 2, 0, -1);
    run_job("simul",    3'd2, 3'd3, 3'd3, 3'd1, 2, 2, TO);

    // Reset in the middle of loading a 40-byte job.
    mon_reset();
    send_cfg(3'd3, 3'd5, 3'd5, 3'd5, n);
    s_valid = 1'b1; idx = 0; guard = 0;
    while (idx < 10 && guard < 100) begin
      s_data = 8'(idx);
      if (s_ready) idx++;
      tick();
      guard++;
    end
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_outs", 32'(outs), 32'(29'h1000_0000));
    rst = 1'b0;
    tick();
    run_job("post_rst", 3'd2, 3'd2, 3'd2, 3'd2, 1, 0, 10);

    for (int j = 0; j < 6; j++) begin
      a = 3'($urandom_range(1, 7));
      b = 3'($urandom_range(1, 7));
      c = ($urandom_range(0, 3) != 0) ? b : 3'($urandom_range(0, 7));
      d = 3'($urandom_range(1, 7));
      run_job($sformatf("rnd%0d", j), a, b, c, d, 2,
              int'($urandom_range(0, 2)), int'($urandom_range(3, 40)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_host_loader.md
# matrix_host_loader

Host-side initiator for the matrix multiplier engine. Accepts one job descriptor (two matrix shapes) and a byte stream of element values. Drives the engine's programming interface: dimensions, values, `start` and `result_read_ready`. Supervises completion with a watchdog, so firmware or a test harness issues one command per multiplication instead of hand-sequencing engine pins.

## Interface
Parameters:
- `TIMEOUT`, default 4096: max cycles in RUN waiting for engine `ready` before error.
- `RD_CYCLES`, default 64: cycles `result_read_ready` is held high after `ready`.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: job descriptor valid.
- `cfg_ready` out 1: high only in IDLE.
- `cfg_m1x`, `cfg_m1y`, `cfg_m2x`, `cfg_m2y` in 3 each: matrix dimensions.
- `s_valid` in 1: element byte valid.
- `s_ready` out 1: high only in LOAD.
- `s_data` in 8: element value.
- `M1Xin`, `M1Yin`, `M2Xin`, `M2Yin` out 3 each: dimensions to engine.
- `program_dim` out 1: dimension write strobe to engine.
- `program_val` out 1: element write strobe to engine.
- `data_in` out 8: element value to engine.
- `start` out 1: engine run request.
- `ready` in 1: engine result-ready status.
- `result_read_ready` out 1: permits engine result readout.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `err` out 1: one-cycle pulse on rejected descriptor or timeout.

## Operation
- All outputs are registered. Reset value of every output is 0, except `cfg_ready`, which is 1.
- States are IDLE, DIM, LOAD, RUN, DRAIN.
- IDLE:
  - On `cfg_valid`, validate the descriptor: all four dims must be nonzero and `cfg_m1y == cfg_m2x`.
  - Invalid: pulse `err` next cycle and stay in IDLE.
  - Valid: latch dims and compute total = m1x*m1y + m2x*m2y (7-bit, max 98). Go to DIM.
- DIM:
  - `M1Xin` through `M2Yin` are driven with the latched dims. They hold these values until the next accepted descriptor; they are not cleared in IDLE except by `rst`.
  - `program_dim` is 1 for exactly 2 cycles, then the block moves to LOAD.
- LOAD:
  - `s_ready` is 1.
  - Each cycle with `s_valid`: `data_in <= s_data`, `program_val <= 1`, element counter increments.
  - Cycles without `s_valid`: `program_val <= 0`; `data_in` holds.
  - After the total-th transfer, go to RUN. `s_ready` drops the same edge, so no extra byte is accepted.
- RUN:
  - `start` is held 1.
  - Watchdog counts cycles from RUN entry.
  - If `ready` is sampled 1: `start <= 0`, go to DRAIN.
  - If the watchdog reaches TIMEOUT first: `start <= 0`, pulse `err`, go to IDLE.
  - If `ready` is 1 on the same cycle the watchdog expires, `ready` wins.
- DRAIN: `result_read_ready` is 1 for RD_CYCLES cycles, then drops. `done` pulses for 1 cycle; return to IDLE.
- `cfg_valid` outside IDLE is ignored. `s_valid` outside LOAD is ignored.
- `rst` in any state: next cycle is IDLE with all outputs at reset values, and counters and watchdog cleared.

## Timing
- Descriptor accepted at edge N: `program_dim` is 1 in cycles N+1 and N+2; dims are valid from N+1.
- First `program_val` is no earlier than N+3.
- LOAD length is `total` cycles with no stalls; each stall cycle adds 1.
- `start` rises the cycle after the last element's `program_val`.
- `ready` sampled 1 at edge R: `start` is 0 and `result_read_ready` is 1 from R+1 through R+RD_CYCLES.
- `done` = 1 at R+RD_CYCLES+1, and `cfg_ready` returns the same cycle.
- Error on descriptor: `err` is 1 one cycle after the `cfg_valid` sample, and `busy` never rises.
- Timeout: `err` is 1 TIMEOUT cycles after `start` rose.

## Test plan
- Valid job: dims 3,5,5,5, 40 bytes of value 1 with no stalls. Required response:
  - `program_dim` is high for 2 cycles.
  - `program_val` is high for exactly 40 consecutive cycles with `data_in` = 1.
  - `start` then rises.
  - Model `ready` 20 cycles later: `result_read_ready` is high for 64 cycles, then `done` pulses once.
- Backpressure: dims 2,2,2,2 (8 bytes), bytes 1..8 with `s_valid` toggling 1/0. Required response:
  - `program_val` pulses exactly 8 times and `data_in` sequence is 1..8.
  - A 9th byte offered after the 8th is not accepted (`s_ready` = 0).
- Rejection:
  - Dims 3,4,5,5: `err` pulses once; `program_dim`, `program_val` and `busy` stay 0.
  - Dims 0,1,1,1: same response.
- Timeout: TIMEOUT=100, `ready` held 0. `err` pulses 100 cycles after `start` rises, `start` drops, and the block returns to IDLE.
- Reset mid-LOAD: assert `rst` after 10 of 40 bytes. Next cycle all outputs are 0 and `cfg_ready` is 1. A fresh 2,2,2,2 job then completes normally with 8 `program_val` pulses.
- Simultaneous: `ready` rises on the cycle the watchdog expires. Required response is DRAIN, then `done`, with no `err`.
